// File: rtl/ha_acc_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ha_acc_pkg : shared widths, half-adder row record and row weighting function
// Revision   : 1.0
// -----------------------------------------------------------------------------
package ha_acc_pkg;

   localparam int ROWS = 4;
   localparam int TW   = 9;
   localparam int BW   = 7;
   localparam int PW   = 16;
   localparam int RW   = 10;
   localparam int PPW  = 13;

   typedef struct packed {
      logic [BW-1:0] b;
      logic [TW-1:0] t;
   } ha_row_t;

   // Carry bits sit one position above the sum bit of the same index.
   function automatic logic [RW-1:0] row_value(input ha_row_t row);
      return {1'b0, row.t} + {2'b00, row.b, 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ha_row_merge.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ha_row_merge : folds one half-adder row (sum + carry vectors) into its value
// Revision     : 1.0
// -----------------------------------------------------------------------------
module ha_row_merge
   import ha_acc_pkg::*;
(
   input  logic [BW-1:0] i_b,
   input  logic [TW-1:0] i_t,
   output logic [RW-1:0] o_r
);

   ha_row_t row_in;

   always_comb begin
      row_in.b = i_b;
      row_in.t = i_t;
      o_r      = row_value(row_in);
   end

endmodule
`default_nettype wire

// File: rtl/ha_array_accumulator.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ha_array_accumulator : two-stage valid/ready reduction of four HA rows to product
// Revision             : 1.0
// -----------------------------------------------------------------------------
module ha_array_accumulator #(
   parameter int ROWS = ha_acc_pkg::ROWS,
   parameter int TW   = ha_acc_pkg::TW,
   parameter int BW   = ha_acc_pkg::BW,
   parameter int PW   = ha_acc_pkg::PW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] ha_array_0_b,
   input  logic [TW-1:0] ha_array_0_t,
   input  logic [BW-1:0] ha_array_1_b,
   input  logic [TW-1:0] ha_array_1_t,
   input  logic [BW-1:0] ha_array_2_b,
   input  logic [TW-1:0] ha_array_2_t,
   input  logic [BW-1:0] ha_array_3_b,
   input  logic [TW-1:0] ha_array_3_t,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] product
);

   import ha_acc_pkg::RW;
   import ha_acc_pkg::PPW;

   logic [BW-1:0]  row_b   [ROWS];
   logic [TW-1:0]  row_t   [ROWS];
   logic [RW-1:0]  row_val [ROWS];

   logic           s2_adv;
   logic           s1_adv;
   logic           in_xfer;
   logic [PPW-1:0] p01_sum;
   logic [PPW-1:0] p23_sum;

   logic           s1_valid_d,  s1_valid_q;
   logic [PPW-1:0] p01_d,       p01_q;
   logic [PPW-1:0] p23_d,       p23_q;
   logic           out_valid_d, out_valid_q;
   logic [PW-1:0]  product_d,   product_q;

   always_comb begin
      row_b[0] = ha_array_0_b;
      row_t[0] = ha_array_0_t;
      row_b[1] = ha_array_1_b;
      row_t[1] = ha_array_1_t;
      row_b[2] = ha_array_2_b;
      row_t[2] = ha_array_2_t;
      row_b[3] = ha_array_3_b;
      row_t[3] = ha_array_3_t;
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      ha_row_merge u_row_merge (
         .i_b (row_b[gi]),
         .i_t (row_t[gi]),
         .o_r (row_val[gi])
      );
   end

   // Odd rows sit two bit positions above their even partner.
   always_comb begin
      p01_sum = {3'b000, row_val[0]} + {1'b0, row_val[1], 2'b00};
      p23_sum = {3'b000, row_val[2]} + {1'b0, row_val[3], 2'b00};
   end

   assign s2_adv    = ~out_valid_q | out_ready;
   assign s1_adv    = ~s1_valid_q | s2_adv;
   assign in_xfer   = in_valid & s1_adv;
   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign product   = product_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      p01_d      = p01_q;
      p23_d      = p23_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         p01_d      = p01_sum;
         p23_d      = p23_sum;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // Full product never exceeds 65025, so dropping the carry-out is exact.
   always_comb begin
      out_valid_d = out_valid_q;
      product_d   = product_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         product_d   = PW'({4'b0000, p01_q} + {p23_q, 4'b0000});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         p01_q       <= '0;
         p23_q       <= '0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         p01_q       <= p01_d;
         p23_q       <= p23_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ha_array_accumulator.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ha_array_accumulator : directed table vectors plus stream/stall/reset runs
// Revision                : 1.0
// -----------------------------------------------------------------------------
module tb_ha_array_accumulator;

   typedef logic [6:0] b_set_t [4];
   typedef logic [8:0] t_set_t [4];

   typedef struct {
      b_set_t      b;
      t_set_t      t;
      logic [15:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] product;
   logic [6:0]  b0 = '0, b1 = '0, b2 = '0, b3 = '0;
   logic [8:0]  t0 = '0, t1 = '0, t2 = '0, t3 = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ha_array_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (b0),
      .ha_array_0_t (t0),
      .ha_array_1_b (b1),
      .ha_array_1_t (t1),
      .ha_array_2_b (b2),
      .ha_array_2_t (t2),
      .ha_array_3_b (b3),
      .ha_array_3_t (t3),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input b_set_t b, input t_set_t t);
      b0 = b[0]; b1 = b[1]; b2 = b[2]; b3 = b[3];
      t0 = t[0]; t1 = t[1]; t2 = t[2]; t3 = t[3];
   endtask

   // Bit-by-bit weighting: t[k] -> 2^(2i+k), b[k] -> 2^(2i+k+1).
   function automatic logic [15:0] ref_product(input b_set_t b, input t_set_t t);
      int unsigned s = 0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 9; k++) if (t[i][k]) s += 32'd1 << (2 * i + k);
         for (int k = 0; k < 7; k++) if (b[i][k]) s += 32'd1 << (2 * i + k + 1);
      end
      return s[15:0];
   endfunction

   function automatic b_set_t rand_b();
      b_set_t r;
      for (int i = 0; i < 4; i++) r[i] = 7'($urandom);
      return r;
   endfunction

   function automatic t_set_t rand_t();
      t_set_t r;
      for (int i = 0; i < 4; i++) r[i] = 9'($urandom);
      return r;
   endfunction

   // One transfer with out_ready high; entered and left at posedge+1.
   task automatic single(input vec_t v, input int idx);
      int lat;
      drive(v.b, v.t);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drive(rand_b(), rand_t());
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("vec%0d_latency", idx), 32'(lat), 32'd2);
      check($sformatf("vec%0d_product", idx), 32'(product), 32'(v.exp));
      @(posedge clk); #1;
   endtask

   task automatic run_stream(input int n, input int stall_start, input int stall_len, input string tag);
      b_set_t      sb [16];
      t_set_t      st [16];
      logic [15:0] expq [$];
      logic [15:0] held = '0;
      logic        held_ok = 1'b0;
      logic        saw_ir_low = 1'b0;
      int          sent = 0, got = 0, cyc = 0, first = -1, last = -1, extra = 0;
      for (int i = 0; i < n; i++) begin
         sb[i] = rand_b();
         st[i] = rand_t();
      end
      while (got < n && cyc < 200) begin
         out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
         if (sent < n) begin
            drive(sb[sent], st[sent]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s_dup: got product %0d with nothing outstanding", tag, product);
            end else begin
               check($sformatf("%s_item%0d", tag, got), 32'(product), 32'(expq.pop_front()));
            end
            got++;
            if (first < 0) first = cyc;
            last    = cyc;
            held_ok = 1'b0;
         end else if (out_valid) begin
            if (held_ok) check($sformatf("%s_stall_hold_c%0d", tag, cyc), 32'(product), 32'(held));
            held    = product;
            held_ok = 1'b1;
            if (!in_ready) saw_ir_low = 1'b1;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_product(sb[sent], st[sent]));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_received"}, 32'(got), 32'(n));
      if (stall_len == 0) check({tag, "_span"}, 32'(last - first + 1), 32'(n));
      else                check({tag, "_in_ready_drop"}, 32'(saw_ir_low), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) extra++;
         @(posedge clk); #1;
      end
      check({tag, "_no_extra"}, 32'(extra), 32'd0);
   endtask

   initial begin
      vec_t vecs [9];
      int   stale;

      for (int i = 0; i < 9; i++) begin
         vecs[i].b   = '{default: 7'h00};
         vecs[i].t   = '{default: 9'h000};
         vecs[i].exp = 16'h0000;
      end
      vecs[1].t[0] = 9'h001;                          vecs[1].exp = 16'd1;
      vecs[2].b[3] = 7'h01;                           vecs[2].exp = 16'd128;
      vecs[3].t[2] = 9'h100;                          vecs[3].exp = 16'd4096;
      vecs[4].b    = '{default: 7'h7F};
      vecs[4].t    = '{default: 9'h1FF};              vecs[4].exp = 16'hFE01;
      vecs[5].t[1] = 9'h001;                          vecs[5].exp = 16'd4;
      vecs[6].b[1] = 7'h40;                           vecs[6].exp = 16'd512;
      vecs[7].t[3] = 9'h1FF;                          vecs[7].exp = 16'd32704;
      vecs[8].t[0] = 9'h003; vecs[8].b[0] = 7'h01;
      vecs[8].t[1] = 9'h002;                          vecs[8].exp = 16'd13;

      #2;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_product", 32'(product), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) single(vecs[i], i);

      run_stream(8, 1000, 0, "stream");
      run_stream(8, 3, 5, "stall");

      // Fill both stages under backpressure, then reset between edges.
      out_ready = 1'b0;
      drive(rand_b(), rand_t());
      in_valid = 1'b1;
      @(posedge clk); #1;
      drive(rand_b(), rand_t());
      @(posedge clk); #1;
      check("prereset_out_valid", 32'(out_valid), 32'd1);
      check("prereset_in_ready", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_product", 32'(product), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      stale = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("post_rst_no_stale", 32'(stale), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
